// File: rtl/code_sequencer.sv
// rtl/code_sequencer.sv - instruction store and code-line sequencer for the training controller
// Holds the program memory and pc, and turns controller strobes into pc/code_count updates.
module code_sequencer #(
  parameter int op_size      = 4,
  parameter int param_a_size = 4,
  parameter int param_b_size = 4,
  parameter int depth        = 64,
  parameter int addr_size    = 6
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         enable,
  input  logic                                         prog_we,
  input  logic [addr_size-1:0]                         prog_addr,
  input  logic [op_size+param_a_size+param_b_size-1:0] prog_data,
  input  logic                                         count_reset,
  input  logic                                         code_active,
  input  logic                                         code_reset,
  output logic [op_size-1:0]                           op,
  output logic [param_a_size-1:0]                      param_a,
  output logic [param_b_size-1:0]                      param_b,
  output logic [param_a_size+param_b_size-1:0]         param_c,
  output logic [31:0]                                  code_count,
  output logic [addr_size-1:0]                         pc,
  output logic                                         running,
  output logic                                         halted
);

  localparam int word_size = op_size + param_a_size + param_b_size;
  localparam logic [addr_size-1:0] last_addr = addr_size'(depth - 1);
  localparam logic [addr_size-1:0] addr_one  = addr_size'(1);

  typedef enum logic [1:0] {
    st_idle,
    st_run,
    st_halt
  } state_t;

  logic [word_size-1:0] mem [depth];

  state_t               state_q, state_d;
  logic [addr_size-1:0] pc_q, pc_d;
  logic [31:0]          code_count_q, code_count_d;
  logic                 running_q, running_d;
  logic                 halted_q, halted_d;

  logic [word_size-1:0] cur_word;
  logic [op_size-1:0]   cur_op;

  assign cur_word = mem[pc_q];
  assign cur_op   = cur_word[word_size-1 -: op_size];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    code_count_d = code_count_q;
    case (state_q)
      st_idle: begin
        if (enable) begin
          state_d      = st_run;
          pc_d         = '0;
          code_count_d = '0;
        end
      end
      st_run: begin
        if (!enable) begin
          state_d      = st_idle;
          pc_d         = '0;
          code_count_d = '0;
        end else if (cur_op == '0) begin
          state_d = st_halt;
        end else if (code_active && !code_reset && pc_q == last_addr) begin
          // Running off the end of the store halts rather than wrapping to line 0.
          state_d = st_halt;
        end else begin
          if (code_reset) begin
            pc_d = '0;
          end else if (code_active) begin
            pc_d = pc_q + addr_one;
          end
          if (count_reset) begin
            code_count_d = '0;
          end else if (code_count_q != 32'hFFFF_FFFF) begin
            code_count_d = code_count_q + 32'd1;
          end
        end
      end
      st_halt: begin
        if (!enable) begin
          state_d      = st_idle;
          pc_d         = '0;
          code_count_d = '0;
        end
      end
      default: begin
        state_d      = st_idle;
        pc_d         = '0;
        code_count_d = '0;
      end
    endcase
    running_d = (state_d == st_run);
    halted_d  = (state_d == st_halt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= st_idle;
      pc_q         <= '0;
      code_count_q <= '0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      code_count_q <= code_count_d;
      running_q    <= running_d;
      halted_q     <= halted_d;
    end
  end

  // The store is never cleared; it only accepts writes while the program is not executing.
  always_ff @(posedge clk) begin
    if (rst_n && prog_we && state_q != st_run) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign op         = running_q ? cur_word[word_size-1 -: op_size] : '0;
  assign param_a    = running_q ? cur_word[param_a_size+param_b_size-1 -: param_a_size] : '0;
  assign param_b    = running_q ? cur_word[param_b_size-1:0] : '0;
  assign param_c    = {param_a, param_b};
  assign code_count = running_q ? code_count_q : '0;
  assign pc         = pc_q;
  assign running    = running_q;
  assign halted     = halted_q;

endmodule
